// File: rtl/pipelined_adder_pkg.sv
// Shared sizing, legality and full-adder helpers for pipelined_adder and its stages.
// Pure functions only; no state.
package pipelined_adder_pkg;

    function automatic int slice_bits(input int width, input int stages);
        return (stages > 0) ? width / stages : width;
    endfunction

    function automatic bit params_legal(input int width, input int stages);
        return (width >= 1) && (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

    // Returns {carry_out, sum_bit}.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
        return {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
    endfunction

endpackage

// File: rtl/adder_stage.sv
// One SLICE-bit ripple slice of pipelined_adder plus its stage register; latency 1 cycle.
// Holds all state while en is low (global stall), so nothing is dropped under backpressure.
module adder_stage
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SLICE = 4,
    parameter int IDX   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             vld_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             c_i,
    output logic             vld_o,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] b_o,
    output logic             c_o
);

    localparam int LO = IDX * SLICE;

    logic [SLICE:0]   cy;
    logic [SLICE-1:0] slice_sum;
    logic [WIDTH-1:0] a_d, a_q;
    logic [WIDTH-1:0] b_d, b_q;
    logic             vld_q, c_q;

    assign cy[0] = c_i;

    for (genvar i = 0; i < SLICE; i++) begin : g_ripple
        assign {cy[i+1], slice_sum[i]} = full_add(a_i[LO+i], b_i[LO+i], cy[i]);
    end

    // The A word turns into the sum in place; consumed B bits are cleared.
    always_comb begin
        a_d = a_i;
        a_d[LO +: SLICE] = slice_sum;
        b_d = b_i;
        b_d[LO +: SLICE] = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            c_q   <= 1'b0;
        end else if (en) begin
            vld_q <= vld_i;
            a_q   <= a_d;
            b_q   <= b_d;
            c_q   <= cy[SLICE];
        end
    end

    assign vld_o = vld_q;
    assign a_o   = a_q;
    assign b_o   = b_q;
    assign c_o   = c_q;

endmodule

// File: rtl/pipelined_adder.sv
// WIDTH-bit adder split into STAGES carry-pipelined slices; latency STAGES cycles, 1 op/cycle.
// Global stall: in_ready = !out_valid | out_ready. PIPELINED_ADDER_SUB_EN adds a sub port (a - b - cin).
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef PIPELINED_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int SLICE = slice_bits(WIDTH, STAGES);

    if (!params_legal(WIDTH, STAGES)) begin : g_illegal_params
        $error("pipelined_adder: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH");
    end

    logic             sub_eff;
    logic             v_pipe [STAGES+1];
    logic             c_pipe [STAGES+1];
    logic [WIDTH-1:0] a_pipe [STAGES+1];
    logic [WIDTH-1:0] b_pipe [STAGES+1];

`ifdef PIPELINED_ADDER_SUB_EN
    assign sub_eff = sub;
`else
    assign sub_eff = 1'b0;
`endif

    // Subtraction is folded in at entry (a + ~b + ~cin), so stages stay pure adders.
    assign v_pipe[0] = in_valid;
    assign a_pipe[0] = a;
    assign b_pipe[0] = sub_eff ? ~b : b;
    assign c_pipe[0] = cin ^ sub_eff;

    assign in_ready = !out_valid || out_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        adder_stage #(
            .WIDTH (WIDTH),
            .SLICE (SLICE),
            .IDX   (k)
        ) u_stage (
            .clk   (clk),
            .rst   (rst),
            .en    (in_ready),
            .vld_i (v_pipe[k]),
            .a_i   (a_pipe[k]),
            .b_i   (b_pipe[k]),
            .c_i   (c_pipe[k]),
            .vld_o (v_pipe[k+1]),
            .a_o   (a_pipe[k+1]),
            .b_o   (b_pipe[k+1]),
            .c_o   (c_pipe[k+1])
        );
    end

    assign out_valid = v_pipe[STAGES];
    assign sum       = a_pipe[STAGES];
    assign cout      = c_pipe[STAGES];

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboarded bench for pipelined_adder: main 8/2 instance plus 8/1, 8/8 and 16/4 sweep instances.
module tb_pipelined_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       in_valid, in_ready, cin, out_valid, out_ready, cout;
    logic [7:0] a, b, sum;
    logic       sub;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [8:0] exp_q[$];
    int         pop_cyc[$];

    typedef struct {
        int          c;
        logic [16:0] e;
    } sw_item_t;

    sw_item_t q1[$], q8[$], q16[$];

    logic        sw_vld, sw_cin;
    logic [15:0] sw_a, sw_b;
    logic        r1, r8, r16, v1, v8, v16, co1, co8, co16;
    logic [7:0]  s1, s8;
    logic [15:0] s16;

    always @(posedge clk) cyc <= cyc + 1;

    pipelined_adder #(.WIDTH(8), .STAGES(2)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin),
`ifdef PIPELINED_ADDER_SUB_EN
        .sub(sub),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout)
    );

    pipelined_adder #(.WIDTH(8), .STAGES(1)) u_w8s1 (
        .clk(clk), .rst(rst), .in_valid(sw_vld), .in_ready(r1),
        .a(sw_a[7:0]), .b(sw_b[7:0]), .cin(sw_cin),
`ifdef PIPELINED_ADDER_SUB_EN
        .sub(1'b0),
`endif
        .out_valid(v1), .out_ready(1'b1), .sum(s1), .cout(co1)
    );

    pipelined_adder #(.WIDTH(8), .STAGES(8)) u_w8s8 (
        .clk(clk), .rst(rst), .in_valid(sw_vld), .in_ready(r8),
        .a(sw_a[7:0]), .b(sw_b[7:0]), .cin(sw_cin),
`ifdef PIPELINED_ADDER_SUB_EN
        .sub(1'b0),
`endif
        .out_valid(v8), .out_ready(1'b1), .sum(s8), .cout(co8)
    );

    pipelined_adder #(.WIDTH(16), .STAGES(4)) u_w16s4 (
        .clk(clk), .rst(rst), .in_valid(sw_vld), .in_ready(r16),
        .a(sw_a), .b(sw_b), .cin(sw_cin),
`ifdef PIPELINED_ADDER_SUB_EN
        .sub(1'b0),
`endif
        .out_valid(v16), .out_ready(1'b1), .sum(s16), .cout(co16)
    );

    function automatic void chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, got, exp, $time);
        end
    endfunction

    function automatic void unexpected(input string nm, input logic [31:0] got);
        checks++;
        errors++;
        $display("FAIL %s: output %0h presented with no result outstanding (t=%0t)", nm, got, $time);
    endfunction

    function automatic logic [8:0] model8(input logic [7:0] x, input logic [7:0] y, input logic c);
        return {1'b0, x} + {1'b0, y} + 9'(c);
    endfunction

    // Main monitor: a transfer happens at the next rising edge when valid & ready here.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            pop_cyc.push_back(cyc);
            if (exp_q.size() == 0) unexpected("main_out", 32'({cout, sum}));
            else chk("main_result", 32'({cout, sum}), 32'(exp_q.pop_front()));
        end
    end

    // Sweep monitors: always-ready sinks, so latency is checked too.
    always @(negedge clk) begin
        sw_item_t it;
        if (!rst && v1) begin
            if (q1.size() == 0) unexpected("w8s1_out", 32'({co1, s1}));
            else begin
                it = q1.pop_front();
                chk("w8s1_result", 32'({co1, s1}), 32'(it.e));
                chk("w8s1_latency", cyc - it.c, 1);
            end
        end
        if (!rst && v8) begin
            if (q8.size() == 0) unexpected("w8s8_out", 32'({co8, s8}));
            else begin
                it = q8.pop_front();
                chk("w8s8_result", 32'({co8, s8}), 32'(it.e));
                chk("w8s8_latency", cyc - it.c, 8);
            end
        end
        if (!rst && v16) begin
            if (q16.size() == 0) unexpected("w16s4_out", 32'({co16, s16}));
            else begin
                it = q16.pop_front();
                chk("w16s4_result", 32'({co16, s16}), 32'(it.e));
                chk("w16s4_latency", cyc - it.c, 4);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [7:0] ta, input logic [7:0] tbv, input logic tc,
                        input logic [8:0] te);
        bit done;
        done = 1'b0;
        in_valid = 1'b1;
        a = ta;
        b = tbv;
        cin = tc;
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(te);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL send_accept: in_ready stayed 0 for 50 cycles, required 1");
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        sw_vld = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() + q1.size() + q8.size() + q16.size()) != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if ((exp_q.size() + q1.size() + q8.size() + q16.size()) != 0) begin
            errors++;
            $display("FAIL drain: %0d results outstanding, required 0",
                     exp_q.size() + q1.size() + q8.size() + q16.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        logic [8:0] v;

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        a = '0;
        b = '0;
        cin = 1'b0;
        sub = 1'b0;
        sw_vld = 1'b0;
        sw_a = '0;
        sw_b = '0;
        sw_cin = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_sum", 32'(sum), 0);
        chk("rst_cout", 32'(cout), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 1);
        @(posedge clk);
        #1;

        // FF + 01: output appears on the second edge after presentation
        send(8'hFF, 8'h01, 1'b0, 9'h100);
        chk("lat_after_edge1", 32'(out_valid), 0);
        @(posedge clk);
        #1;
        chk("lat_after_edge2", 32'(out_valid), 1);
        chk("ff01_sum", 32'(sum), 32'h00);
        chk("ff01_cout", 32'(cout), 1);
        drain();

        // Exhaustive low-nibble stream, back to back
        base = pop_cyc.size();
        for (int i = 0; i < 512; i++) begin
            v = 9'(i);
            send({4'hF, v[8:5]}, {4'hF, v[4:1]}, v[0], model8({4'hF, v[8:5]}, {4'hF, v[4:1]}, v[0]));
        end
        drain();
        chk("stream_count", pop_cyc.size() - base, 512);
        if (pop_cyc.size() >= base + 512)
            chk("stream_gapless", pop_cyc[base+511] - pop_cyc[base], 511);

        // Backpressure: result must hold for 3 stalled cycles
        send(8'h80, 8'h80, 1'b1, 9'h101);
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("stall_out_valid", 32'(out_valid), 1);
            chk("stall_in_ready", 32'(in_ready), 0);
            chk("stall_sum", 32'(sum), 32'h01);
            chk("stall_cout", 32'(cout), 1);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("stall_released", 32'(out_valid), 0);
        drain();

        // in_valid 1,0,1
        base = pop_cyc.size();
        send(8'h12, 8'h34, 1'b0, 9'h046);
        idle(1);
        send(8'hF0, 8'h0F, 1'b1, 9'h100);
        drain();
        chk("bubble_count", pop_cyc.size() - base, 2);
        if (pop_cyc.size() >= base + 2)
            chk("bubble_spacing", pop_cyc[base+1] - pop_cyc[base], 2);

        // Reset with two operations in flight
        out_ready = 1'b0;
        send(8'h01, 8'h02, 1'b0, 9'h003);
        send(8'h03, 8'h04, 1'b0, 9'h007);
        rst = 1'b1;
        #1;
        chk("rst_mid_out_valid", 32'(out_valid), 0);
        chk("rst_mid_sum", 32'(sum), 0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        base = pop_cyc.size();
        send(8'h10, 8'h20, 1'b0, 9'h030);
        drain();
        idle(6);
        chk("rst_mid_outputs", pop_cyc.size() - base, 1);

`ifdef PIPELINED_ADDER_SUB_EN
        sub = 1'b1;
        send(8'h05, 8'h07, 1'b0, 9'h0FE);
        drain();
        sub = 1'b0;
`endif

        // Parameter sweep with random operands and occasional bubbles
        for (int i = 0; i < 40; i++) begin
            sw_vld = (i % 5) != 4;
            sw_a = 16'($urandom);
            sw_b = 16'($urandom);
            sw_cin = 1'($urandom);
            @(negedge clk);
            chk("sweep_in_ready", 32'({r1, r8, r16}), 32'b111);
            if (sw_vld) begin
                q1.push_back('{cyc, 17'(model8(sw_a[7:0], sw_b[7:0], sw_cin))});
                q8.push_back('{cyc, 17'(model8(sw_a[7:0], sw_b[7:0], sw_cin))});
                q16.push_back('{cyc, {1'b0, sw_a} + {1'b0, sw_b} + 17'(sw_cin)});
            end
            @(posedge clk);
            #1;
        end
        sw_vld = 1'b0;
        drain();
        idle(10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
